fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h01000000, PC value reported on deq_PC out of reset.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enq_valid  input  1  fetch stage presents a PC/instruction pair this cycle.
REQ-006 SHALL have port enq_PC  input  32  PC of the fetched instruction.
REQ-007 SHALL have port enq_instr  input  32  fetched instruction word.
REQ-008 SHALL have port stall_PC  output  1  back-pressure to fetch; high means no enqueue accepted.
REQ-009 SHALL have port flush  input  1  branch/jump redirect (same cycle fetch receives set_PC); discards all entries.
REQ-010 SHALL have port deq_ready  input  1  decode consumes the head entry this cycle.
REQ-011 SHALL have port deq_valid  output  1  head entry valid.
REQ-012 SHALL have port deq_PC  output  32  head entry PC.
REQ-013 SHALL have port deq_instr  output  32  head entry instruction.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 SHALL store entries in a circular buffer with read/write pointers of width $clog2(DEPTH), wrapping DEPTH-1 -> 0.
REQ-016 SHALL drive stall_PC = (count == DEPTH), from registered state only.
REQ-017 SHALL accept an enqueue on a posedge with enq_valid && !stall_PC && !flush, writing at the write pointer and then incrementing it.
REQ-018 SHALL perform a dequeue on a posedge with deq_valid && deq_ready && !flush, then increment the read pointer.
REQ-019 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and update both pointers.
REQ-020 SHALL, when full, reject enqueue even if a dequeue occurs the same cycle; stall_PC deasserts the next cycle.
REQ-021 SHALL ignore deq_ready when deq_valid is low, with no underflow and no pointer change.
REQ-022 SHALL, on flush, reset both pointers and count to 0 on that posedge and drop the same-cycle enqueue and dequeue; flush overrides all other inputs.
REQ-023 SHALL drive deq_valid = (count != 0) and deq_PC/deq_instr from the head entry (zero-latency bypass case in REQ-028).
REQ-024 SHALL hold deq_PC/deq_instr stable while deq_valid && !deq_ready.
REQ-025 SHALL give one-cycle enqueue-to-dequeue latency: an entry written at edge N is visible at the head after edge N.

Reset
REQ-026 SHALL, while reset is low, asynchronously clear pointers and count, drive deq_valid=0, stall_PC=0, deq_PC=RESET_PC, deq_instr=32'h00000013 (NOP); storage contents need not be cleared.
REQ-027 SHALL accept the first enqueue on the first posedge after reset deasserts; reset asserted mid-operation discards all entries immediately.

Configuration
REQ-028 SHALL, with FETCH_QUEUE_BYPASS_EN defined, assert deq_valid combinationally when count==0 && enq_valid && !flush, driving deq_PC/deq_instr from enq_PC/enq_instr; if deq_ready is also high the entry is consumed without being written and count stays 0.
REQ-029 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from enq_* or flush to deq_*; latency per REQ-025.

Verification
REQ-030 SHALL cover: reset, enq 0x01000000/0x00100093, deq_ready=0 -> next cycle deq_valid=1, deq_PC=0x01000000, count=1.
REQ-031 SHALL cover: DEPTH=4, 5 consecutive enqueues, deq_ready=0 -> stall_PC=1 after 4th, 5th dropped, count=4.
REQ-032 SHALL cover: full queue, enq_valid=1, deq_ready=1 one cycle -> count=3, stall_PC=0 next cycle, head PC advances by 4.
REQ-033 SHALL cover: count=3, flush with enq_valid=1, deq_ready=1 -> next cycle count=0, deq_valid=0, then new-path enq 0x01000100 is head.
REQ-034 SHALL cover: 10 enqueues interleaved with dequeues (pointer wrap) -> dequeue order exactly matches enqueue order, no loss or duplication.
REQ-035 SHALL cover: with FETCH_QUEUE_BYPASS_EN, empty queue, enq_valid=1, deq_ready=1 -> same-cycle deq_valid=1 with enq data, count remains 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of PC/instruction pairs with flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards an enqueue straight to the head when empty.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h01000000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enq_valid,
   input  logic [31:0]                  enq_PC,
   input  logic [31:0]                  enq_instr,
   output logic                         stall_PC,
   input  logic                         flush,
   input  logic                         deq_ready,
   output logic                         deq_valid,
   output logic [31:0]                  deq_PC,
   output logic [31:0]                  deq_instr,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;

   logic empty;
   logic full;
   logic bypass_hit;
   logic bypass_take;
   logic do_enq;
   logic do_deq;
   logic wr_en;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign stall_PC = full;
   assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass_hit = empty && enq_valid && !flush;
`else
   assign bypass_hit = 1'b0;
`endif

   // An empty queue reports the reset PC and a NOP so the head never shows stale storage.
   always_comb begin
      deq_valid = !empty;
      deq_PC    = RESET_PC;
      deq_instr = NOP;
      if (bypass_hit) begin
         deq_valid = 1'b1;
         deq_PC    = enq_PC;
         deq_instr = enq_instr;
      end else if (!empty) begin
         deq_PC    = mem[rd_ptr].pc;
         deq_instr = mem[rd_ptr].instr;
      end
   end

   assign do_enq      = enq_valid && !full && !flush;
   assign do_deq      = deq_valid && deq_ready && !flush;
   // A bypassed entry consumed the same cycle never touches storage or pointers.
   assign bypass_take = bypass_hit && deq_ready;
   assign wr_en       = do_enq && !bypass_take;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (!bypass_take) begin
         if (do_enq) wr_ptr <= wr_ptr + PW'(1);
         if (do_deq) rd_ptr <= rd_ptr + PW'(1);
         case ({do_enq, do_deq})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; validity comes solely from count_q.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= '{pc: enq_PC, instr: enq_instr};
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of accepted entries compared at the head.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h01000000;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enq_valid = 1'b0;
   logic [31:0] enq_PC = '0;
   logic [31:0] enq_instr = '0;
   logic        stall_PC;
   logic        flush = 1'b0;
   logic        deq_ready = 1'b0;
   logic        deq_valid;
   logic [31:0] deq_PC;
   logic [31:0] deq_instr;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb [$];

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (enq_valid),
      .enq_PC    (enq_PC),
      .enq_instr (enq_instr),
      .stall_PC  (stall_PC),
      .flush     (flush),
      .deq_ready (deq_ready),
      .deq_valid (deq_valid),
      .deq_PC    (deq_PC),
      .deq_instr (deq_instr),
      .count     (count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Drive one cycle, check the head against the scoreboard, clock it, update the model.
   task automatic cycle(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl);
      logic        exp_valid;
      logic [63:0] head;
      logic        m_deq;
      logic        m_enq;
      enq_valid = ev; enq_PC = pc; enq_instr = ins; deq_ready = dr; flush = fl;
      #1;
      exp_valid = (sb.size() != 0) || (BYP && ev && !fl);
      check("stall", stall_PC, sb.size() == DEPTH);
      check("valid", deq_valid, exp_valid);
      check("count", count, sb.size());
      if (exp_valid) begin
         head = (sb.size() != 0) ? sb[0] : {pc, ins};
         check("head", {deq_PC, deq_instr}, head);
      end
      @(posedge clock); #1;
      if (fl) begin
         sb.delete();
      end else begin
         m_deq = exp_valid && dr;
         m_enq = ev && (sb.size() != DEPTH);
         if (!(sb.size() == 0 && m_deq && m_enq)) begin
            if (m_deq) void'(sb.pop_front());
            if (m_enq) sb.push_back({pc, ins});
         end
      end
      enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
   endtask

   initial begin
      @(posedge clock); #1;
      check("rst_valid", deq_valid, 1'b0);
      check("rst_stall", stall_PC, 1'b0);
      check("rst_pc",    deq_PC, RESET_PC);
      check("rst_instr", deq_instr, 32'h00000013);
      check("rst_count", count, 3'd0);
      reset = 1'b1;

      // First enqueue right after reset, visible one cycle later.
      cycle(1'b1, 32'h01000000, 32'h00100093, 1'b0, 1'b0);
      check("first_valid", deq_valid, 1'b1);
      check("first_pc",    deq_PC, 32'h01000000);
      check("first_count", count, 3'd1);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);

      // Fill past capacity: fifth enqueue is dropped.
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 32'h2000 + 32'(4*i), 32'h100 + 32'(i), 1'b0, 1'b0);
      check("full_count", count, 3'd4);
      check("full_stall", stall_PC, 1'b1);

      // Full with enqueue and dequeue together: only the dequeue happens.
      cycle(1'b1, 32'h3000, 32'h300, 1'b1, 1'b0);
      check("fd_count", count, 3'd3);
      check("fd_stall", stall_PC, 1'b0);
      check("fd_head",  deq_PC, 32'h2004);

      // Flush overrides same-cycle enqueue and dequeue.
      cycle(1'b1, 32'h4000, 32'h400, 1'b1, 1'b1);
      check("fl_count", count, 3'd0);
      check("fl_valid", deq_valid, 1'b0);
      cycle(1'b1, 32'h01000100, 32'h00000013, 1'b0, 1'b0);
      check("fl_newhead", deq_PC, 32'h01000100);
      check("fl_newvalid", deq_valid, 1'b1);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);

      // Interleaved traffic wrapping the pointers; scoreboard enforces order.
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 32'h5000 + 32'(4*i), $urandom, (i % 3) != 0, 1'b0);
      for (int k = 0; k < 20 && sb.size() != 0; k++)
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
      check("drain_count", count, 3'd0);
      check("drain_valid", deq_valid, 1'b0);

      // Asynchronous reset mid-operation.
      cycle(1'b1, 32'h7000, 32'h700, 1'b0, 1'b0);
      cycle(1'b1, 32'h7004, 32'h704, 1'b0, 1'b0);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_count", count, 3'd0);
      check("mid_rst_valid", deq_valid, 1'b0);
      check("mid_rst_pc",    deq_PC, RESET_PC);
      check("mid_rst_instr", deq_instr, 32'h00000013);
      sb.delete();
      #1 reset = 1'b1;
      @(posedge clock); #1;
      cycle(1'b1, 32'h8000, 32'h800, 1'b0, 1'b0);
      check("post_rst_head", deq_PC, 32'h8000);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);

      // Empty queue with enqueue and dequeue in the same cycle.
      cycle(1'b1, 32'h6000, 32'h600, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
      check("byp_count", count, 3'd0);
`else
      check("byp_count", count, 3'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
